// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
//   if_state_t       : fetch FSM states (FETCH, DROP, HOLD)
//   PC_STEP          : default sequential PC increment
//   DEFAULT_RESET_PC : default PC after reset
//   ALIGN_MASK       : clears the byte-offset bits of a word address
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } if_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: one-entry {pc, instr} parking register used while the
// pipeline is stalled and a fetched word must not be lost.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture pc_in/instr_in and mark the entry valid
//   clear             : empty the entry (takes priority over load)
//   pc_in, instr_in   : word to park
//   valid, pc, instr  : current contents
import if_pkg::*;

module if_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage of the five-stage pipeline. Owns the PC, fetches
// from instruction memory over a req/ready handshake, loads the IF/ID
// register, parks one word during stalls and squashes wrong-path fetches
// on an ID redirect (no delay slot).
//   clk, rst_n            : clock, asynchronous active-low reset
//   jumpif, jumpaddr      : redirect request and target from ID
//   stall                 : freeze IF/ID and PC
//   imem_req, imem_addr   : fetch request and address
//   imem_rdata, imem_ready: instruction word and response strobe
//   if_pc, if_instr       : IF/ID register contents
//   if_valid              : IF/ID holds a real instruction (0 = bubble)
import if_pkg::*;

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = if_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = if_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jumpif,
    input  logic [31:0] jumpaddr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
);

    if_state_t   state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] req_addr, req_addr_d;
    logic [31:0] target;
    logic        redirect;
    logic        ifid_load, ifid_bubble;
    logic [31:0] ifid_pc_d, ifid_instr_d;
    logic        hold_load, hold_clear, hold_valid;
    logic [31:0] hold_pc, hold_instr;

    assign target   = jumpaddr & ALIGN_MASK;
    // A redirect raised during a stall is ignored; ID re-issues it later.
    assign redirect = jumpif && !stall;

    // The parked-word flag is set exactly while in HOLD, so it doubles as
    // the "no request" condition; reset forces the request low at once.
    assign imem_req  = rst_n && !hold_valid;
    assign imem_addr = req_addr;

    if_hold_buf u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .clear    (hold_clear),
        .pc_in    (req_addr),
        .instr_in (imem_rdata),
        .valid    (hold_valid),
        .pc       (hold_pc),
        .instr    (hold_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_addr_d   = req_addr;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_pc_d    = req_addr;
        ifid_instr_d = imem_rdata;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;

        case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_d        = target;
                    // An accepted response is simply dropped; otherwise the
                    // address must stay put until the old fetch completes.
                    if (imem_ready) begin
                        req_addr_d = target;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ready && !stall) begin
                    ifid_load  = 1'b1;
                    req_addr_d = req_addr + PC_STEP;
                    pc_d       = req_addr + PC_STEP;
                end else if (imem_ready) begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    req_addr_d = redirect ? target : pc;
                    state_d    = FETCH;
                end
                if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end

            HOLD: begin
                if (redirect) begin
                    hold_clear  = 1'b1;
                    ifid_bubble = 1'b1;
                    req_addr_d  = target;
                    pc_d        = target;
                    state_d     = FETCH;
                end else if (!stall) begin
                    hold_clear   = 1'b1;
                    ifid_load    = 1'b1;
                    ifid_pc_d    = hold_pc;
                    ifid_instr_d = hold_instr;
                    req_addr_d   = hold_pc + PC_STEP;
                    pc_d         = hold_pc + PC_STEP;
                    state_d      = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            pc       <= pc_d;
            req_addr <= req_addr_d;
            if (ifid_load) begin
                if_valid <= 1'b1;
                if_pc    <= ifid_pc_d;
                if_instr <= ifid_instr_d;
            end else if (ifid_bubble) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: self-checking bench for if_fetch_unit. A memory model
// with a programmable wait count answers fetches; accepted responses that
// should reach ID are queued and matched against IF/ID as ID consumes it.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        jumpif;
    logic [31:0] jumpaddr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    int wait_cycles = 0;
    int wait_cnt    = 0;

    logic [63:0] sb[$];
    logic [63:0] exp_entry;
    logic        drop_pending = 1'b0;
    logic        redir;

    if_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jumpif     (jumpif),
        .jumpaddr   (jumpaddr),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Memory model: answers after wait_cycles cycles of a held request.
    assign imem_ready = imem_req && (wait_cnt >= wait_cycles);
    assign imem_rdata = memWord(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else if (imem_req && imem_ready) begin
            wait_cnt <= 0;
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard: ID consumes IF/ID on every unstalled cycle; responses are
    // queued unless squashed by a redirect or an earlier pending drop.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            drop_pending = 1'b0;
        end else begin
            if (if_valid && !stall) begin
                checkOutput("sb_pending", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    exp_entry = sb.pop_front();
                    checkOutput("sb_if_pc", 64'(if_pc), 64'(exp_entry[63:32]));
                    checkOutput("sb_if_instr", 64'(if_instr), 64'(exp_entry[31:0]));
                end
            end
            redir = jumpif && !stall;
            if (imem_req && imem_ready) begin
                if (!(drop_pending || redir)) begin
                    sb.push_back({imem_addr, memWord(imem_addr)});
                end
                drop_pending = 1'b0;
            end else if (imem_req && redir) begin
                drop_pending = 1'b1;
            end else if (!imem_req && redir && sb.size() != 0) begin
                void'(sb.pop_back());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic j, input logic [31:0] a, input logic s);
        jumpif   = j;
        jumpaddr = a;
        stall    = s;
    endtask

    task automatic resetDut(input int waits);
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        wait_cycles = waits;
        #1;
        checkOutput("rst_req", 64'(imem_req), 64'd0);
        checkOutput("rst_valid", 64'(if_valid), 64'd0);
        checkOutput("rst_if_pc", 64'(if_pc), 64'd0);
        checkOutput("rst_if_instr", 64'(if_instr), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("first_req", 64'(imem_req), 64'd1);
        checkOutput("first_addr", 64'(imem_addr), 64'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Zero-wait sequential fetch, redirect, and PC wrap.
        resetDut(0);
        checkOutput("c0_valid", 64'(if_valid), 64'd0);
        tick();
        checkOutput("seq_addr4", 64'(imem_addr), 64'h4);
        checkOutput("seq_valid", 64'(if_valid), 64'd1);
        checkOutput("seq_if_pc0", 64'(if_pc), 64'h0);
        tick();
        checkOutput("seq_addr8", 64'(imem_addr), 64'h8);
        checkOutput("seq_if_pc4", 64'(if_pc), 64'h4);
        applyStimulus(1'b1, 32'h0000_0103, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("redir_addr", 64'(imem_addr), 64'h100);
        checkOutput("redir_bubble", 64'(if_valid), 64'd0);
        tick();
        checkOutput("redir_if_pc", 64'(if_pc), 64'h100);
        checkOutput("redir_valid", 64'(if_valid), 64'd1);
        checkOutput("redir_next", 64'(imem_addr), 64'h104);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap_top", 64'(imem_addr), 64'hFFFF_FFFC);
        tick();
        checkOutput("wrap_zero", 64'(imem_addr), 64'h0);
        checkOutput("wrap_if_pc", 64'(if_pc), 64'hFFFF_FFFC);
        tick();
        checkOutput("wrap_if_pc0", 64'(if_pc), 64'h0);

        // Stall for four edges while the word from 12 arrives; an
        // unstalled-looking redirect during the stall must be ignored.
        resetDut(0);
        tick();
        tick();
        tick();
        checkOutput("pre_stall_addr", 64'(imem_addr), 64'hC);
        checkOutput("pre_stall_if_pc", 64'(if_pc), 64'h8);
        applyStimulus(1'b1, 32'h500, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("hold_req", 64'(imem_req), 64'd0);
        checkOutput("hold_if_pc", 64'(if_pc), 64'h8);
        checkOutput("hold_valid", 64'(if_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_req_n", 64'(imem_req), 64'd0);
            checkOutput("hold_if_pc_n", 64'(if_pc), 64'h8);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("release_if_pc", 64'(if_pc), 64'hC);
        checkOutput("release_if_instr", 64'(if_instr), 64'(memWord(32'hC)));
        checkOutput("release_req", 64'(imem_req), 64'd1);
        checkOutput("release_addr", 64'(imem_addr), 64'h10);
        tick();
        checkOutput("release_if_pc16", 64'(if_pc), 64'h10);

        // Three-wait memory; redirect in the first wait cycle of fetch 4.
        resetDut(3);
        tick();
        tick();
        tick();
        checkOutput("ws_addr0", 64'(imem_addr), 64'h0);
        checkOutput("ws_valid0", 64'(if_valid), 64'd0);
        tick();
        checkOutput("ws_if_pc0", 64'(if_pc), 64'h0);
        checkOutput("ws_addr4", 64'(imem_addr), 64'h4);
        applyStimulus(1'b1, 32'h40, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("drop_addr", 64'(imem_addr), 64'h4);
            checkOutput("drop_valid", 64'(if_valid), 64'd0);
            tick();
        end
        checkOutput("drop_new_addr", 64'(imem_addr), 64'h40);
        checkOutput("drop_new_valid", 64'(if_valid), 64'd0);
        tick();
        applyStimulus(1'b1, 32'h80, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("drop2_addr", 64'(imem_addr), 64'h40);
        checkOutput("drop2_req", 64'(imem_req), 64'd1);

        // Asynchronous reset in the middle of a DROP wait.
        #2;
        resetDut(0);
        tick();
        checkOutput("post_rst_addr", 64'(imem_addr), 64'h4);
        checkOutput("post_rst_if_pc", 64'(if_pc), 64'h0);
        checkOutput("post_rst_valid", 64'(if_valid), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
